// File: rtl/seq_mpy_pkg.sv
// seq_mpy_pkg: state encoding and step-counter sizing shared by the
// sequential multiplier and its step datapath.
package seq_mpy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Wide enough to hold W itself, not just W-1.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mpy_step.sv
// seq_mpy_step: one shift-add (or shift-subtract) step of the multiplier.
// The subtract path weights the sign bit of a two's-complement multiplier.
module seq_mpy_step
    import seq_mpy_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = cnt_w(W)
) (
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] a,
    input  logic           b_bit,
    input  logic [CW-1:0]  idx,
    input  logic           mode,
    input  logic           last,
    output logic [2*W-1:0] acc_next
);
    logic [2*W-1:0] partial;

    assign partial = a << idx;

    always_comb begin
        acc_next = acc;
        if (b_bit) begin
            acc_next = (mode && last) ? acc - partial : acc + partial;
        end
    end

endmodule

// File: rtl/seq_mpy.sv
// seq_mpy: start/busy sequential multiplier, one multiplier bit per cycle,
// signed or unsigned per operation. Define SEQ_MPY_EARLY_TERM_EN for early termination.
module seq_mpy
    import seq_mpy_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           busy,
    output logic [2*W-1:0] out,
    output logic           out_valid
);
    localparam int CW = cnt_w(W);

    state_t         state;
    state_t         state_next;
    logic [2*W-1:0] a_reg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   b_reg;
    logic [CW-1:0]  idx;
    logic           mode;
    logic           accept;
    logic           last_step;
    logic           early;

    assign accept    = start && (state != RUN);
    assign last_step = (idx == CW'(W - 1));
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    // b_reg shifts right each step, so "remaining multiplier bits all zero"
    // is just b_reg == 0; a negative signed multiplier keeps its top bit.
`ifdef SEQ_MPY_EARLY_TERM_EN
    assign early = (b_reg == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (early || last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand registers carry no reset: they are always loaded before use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_reg <= is_signed ? {{W{in_a[W-1]}}, in_a} : {{W{1'b0}}, in_a};
            b_reg <= in_b;
            mode  <= is_signed;
        end else if (state == RUN) begin
            b_reg <= {1'b0, b_reg[W-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            acc <= '0;
            idx <= '0;
            out <= '0;
        end else if (accept) begin
            acc <= '0;
            idx <= '0;
        end else if (state == RUN) begin
            if (early) begin
                out <= acc;
            end else begin
                acc <= acc_step;
                idx <= idx + CW'(1);
                if (last_step) begin
                    out <= acc_step;
                end
            end
        end
    end

    seq_mpy_step #(
        .W  (W),
        .CW (CW)
    ) u_step (
        .acc      (acc),
        .a        (a_reg),
        .b_bit    (b_reg[0]),
        .idx      (idx),
        .mode     (mode),
        .last     (last_step),
        .acc_next (acc_step)
    );

endmodule

// File: tb/tb_seq_mpy.sv
// tb_seq_mpy: scoreboard bench for seq_mpy at W=8 and W=16.
module tb_seq_mpy;

`ifdef SEQ_MPY_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        CLK    = 1'b0;
    logic        reset  = 1'b1;

    logic        start8 = 1'b0;
    logic        sgn8   = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8;
    logic        ov8;
    logic [15:0] out8;

    logic        start16 = 1'b0;
    logic        sgn16   = 1'b0;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic        busy16;
    logic        ov16;
    logic [31:0] out16;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t sb[$];

    seq_mpy #(.W(8)) dut8 (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start8),
        .is_signed (sgn8),
        .in_a      (a8),
        .in_b      (b8),
        .busy      (busy8),
        .out       (out8),
        .out_valid (ov8)
    );

    seq_mpy #(.W(16)) dut16 (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start16),
        .is_signed (sgn16),
        .in_a      (a16),
        .in_b      (b16),
        .busy      (busy16),
        .out       (out16),
        .out_valid (ov16)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Latency from the cycle start is presented to the cycle out_valid is seen.
    function automatic int lat_of(input int w, input logic [31:0] b);
        int h;
        h = -1;
        for (int i = 0; i < w; i++) if (b[i]) h = i;
        if (EARLY && (h + 3 < w + 1)) return h + 3;
        return w + 1;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p[15:0];
    endfunction

    // Presents start for the current cycle, records the expectation, then drops start.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] expv);
        exp_t e;
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        sgn8   = s;
        e.prod = expv;
        e.due  = cyc + lat_of(8, {24'd0, b});
        sb.push_back(e);
        @(posedge CLK);
        #1;
        start8 = 1'b0;
    endtask

    task automatic wait8(input string name, output int busy_cnt);
        exp_t e;
        bit   got;
        int   n;
        got      = 1'b0;
        n        = 0;
        busy_cnt = 0;
        while (!got && n < 40) begin
            @(negedge CLK);
            n++;
            if (ov8) got = 1'b1;
            else if (busy8) busy_cnt++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: out_valid not seen within %0d cycles", name, n);
            if (sb.size() > 0) e = sb.pop_front();
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected out_valid, out=%0d, none required", name, out8);
        end else begin
            e = sb.pop_front();
            if (out8 !== e.prod) begin
                errors++;
                $display("FAIL %s out: got %0d (0x%h) required %0d (0x%h)",
                         name, out8, out8, e.prod, e.prod);
            end
            checks++;
            if (cyc !== e.due) begin
                errors++;
                $display("FAIL %s latency: out_valid at cycle %0d required %0d", name, cyc, e.due);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks += 5;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_busy8: got %b required 0", busy8); end
        if (ov8 !== 1'b0) begin errors++; $display("FAIL rst_valid8: got %b required 0", ov8); end
        if (out8 !== 16'd0) begin errors++; $display("FAIL rst_out8: got %0d required 0", out8); end
        if (busy16 !== 1'b0) begin errors++; $display("FAIL rst_busy16: got %b required 0", busy16); end
        if (out16 !== 32'd0) begin errors++; $display("FAIL rst_out16: got %0d required 0", out16); end
        reset = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_signed_basic();
        int bc;
        issue8(8'd73, 8'd91, 1'b1, 16'd6643);
        wait8("s73x91", bc);
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL s73x91 busy: high %0d cycles required 8", bc); end
        repeat (3) @(negedge CLK);
        checks += 2;
        if (out8 !== 16'd6643) begin errors++; $display("FAIL out_hold: got %0d required 6643", out8); end
        if (ov8 !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b required 0", ov8); end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [6] = '{8'h80, 8'hFF, 8'hFF, 8'd0,  8'd10, 8'd100};
        logic [7:0]  tb [6] = '{8'h80, 8'hFF, 8'hFF, 8'd43, 8'd0,  8'd60};
        logic        ts [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        logic [15:0] tp [6] = '{16'd16384, 16'd65025, 16'd1, 16'd0, 16'd0, 16'd6000};
        int bc;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            issue8(ta[i], tb[i], ts[i], tp[i]);
            wait8($sformatf("corner%0d", i), bc);
        end
    endtask

    task automatic test_ignored_start();
        int bc;
        int extra;
        @(posedge CLK);
        #1;
        issue8(8'd12, 8'd79, 1'b0, 16'd948);
        repeat (3) @(negedge CLK);
        start8 = 1'b1;
        a8     = 8'd5;
        b8     = 8'd5;
        repeat (2) @(negedge CLK);
        start8 = 1'b0;
        wait8("ignore_12x79", bc);
        extra = 0;
        repeat (15) begin
            @(negedge CLK);
            if (ov8 || busy8) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_extra: %0d cycles busy/valid after result, required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        @(posedge CLK);
        #1;
        issue8(8'd100, 8'd200, 1'b0, 16'd20000);
        repeat (3) @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy8); end
        if (ov8 !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", ov8); end
        if (out8 !== 16'd0) begin errors++; $display("FAIL rmid_out: got %0d required 0", out8); end
        sb.delete();
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        issue8(8'd10, 8'd14, 1'b0, 16'd140);
        wait8("after_rst_10x14", bc);
    endtask

    task automatic test_back_to_back();
        int         bc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        @(posedge CLK);
        #1;
        issue8(8'd73, 8'd91, 1'b1, 16'd6643);
        wait8("b2b_first", bc);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            issue8(ra, rb, rs, model8(ra, rb, rs));
            checks++;
            if (ov8 !== 1'b0) begin errors++; $display("FAIL b2b_pulse%0d: out_valid got %b required 0", i, ov8); end
            wait8($sformatf("b2b%0d", i), bc);
        end
    endtask

    task automatic test_w16();
        int due;
        int n;
        @(posedge CLK);
        #1;
        start16 = 1'b1;
        a16     = -16'sd300;
        b16     = 16'd250;
        sgn16   = 1'b1;
        due     = cyc + lat_of(16, 32'd250);
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        n = 0;
        while (!ov16 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks += 2;
        if (out16 !== 32'hFFFE_DB08) begin
            errors++;
            $display("FAIL w16_out: got 0x%h required 0xfffedb08", out16);
        end
        if (cyc !== due) begin
            errors++;
            $display("FAIL w16_latency: out_valid at cycle %0d required %0d", cyc, due);
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_corners();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
